// File: rtl/video_timing_pkg.sv
// Raster timing constants and count helpers shared by the counter stage and the decode stage.
package video_timing_pkg;

  localparam int CNT_W = 9;

  localparam int unsigned H_TOTAL      = 384;
  localparam int unsigned H_ACTIVE     = 256;
  localparam int unsigned H_SYNC_START = 288;
  localparam int unsigned H_SYNC_END   = 320;

  localparam int unsigned V_TOTAL      = 262;
  localparam int unsigned V_ACTIVE     = 240;
  localparam int unsigned V_SYNC_START = 244;
  localparam int unsigned V_SYNC_END   = 247;

  // Half-open window: true for win_start <= count < win_end.
  function automatic logic in_window(input logic [CNT_W-1:0] count,
                                     input int unsigned win_start,
                                     input int unsigned win_end);
    return (32'(count) >= win_start) && (32'(count) < win_end);
  endfunction

  // Count the counter will hold after this edge; load clamps to modulus-1.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic en,
                                                  input logic load,
                                                  input logic [CNT_W-1:0] din,
                                                  input int unsigned modulus);
    logic [CNT_W-1:0] last;
    last = CNT_W'(modulus - 1);
    if (load) return (din > last) ? last : din;
    if (!en) return cur;
    return (cur == last) ? '0 : cur + 1'b1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with synchronous clamped load; wrap flags the enabled edge that rolls over to 0.
module mod_counter #(
  parameter int WIDTH   = 9,
  parameter int MODULUS = 384
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;

  // A load cycle never reports a wrap, so cascaded stages and strobes stay quiet.
  always_comb begin
    q_d  = q_q;
    wrap = 1'b0;
    if (load) begin
      q_d = (din > LAST) ? LAST : din;
    end else if (en) begin
      if (q_q == LAST) begin
        q_d  = '0;
        wrap = 1'b1;
      end else begin
        q_d = q_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/video_timing_decoder.sv
// Raster timing: cascaded h/v counters plus registered sync/blank decodes and eol/eof strobes.
// Decodes are computed from next-count values so they line up with hcount/vcount each cycle.
module video_timing_decoder
  import video_timing_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             preset,
  input  logic [CNT_W-1:0] preset_h,
  input  logic [CNT_W-1:0] preset_v,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             hblank,
  output logic             vblank,
  output logic             blank,
  output logic             eol,
  output logic             eof
);

  logic             h_wrap, v_wrap, v_en;
  logic [CNT_W-1:0] h_nxt, v_nxt;

  logic hsync_n_q, hsync_n_d;
  logic vsync_n_q, vsync_n_d;
  logic hblank_q, hblank_d;
  logic vblank_q, vblank_d;
  logic blank_q, blank_d;
  logic eol_q, eol_d;
  logic eof_q, eof_d;

  assign v_en = h_wrap & pix_en;

  mod_counter #(.WIDTH(CNT_W), .MODULUS(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .load  (preset),
    .din   (preset_h),
    .q     (hcount),
    .wrap  (h_wrap)
  );

  mod_counter #(.WIDTH(CNT_W), .MODULUS(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .load  (preset),
    .din   (preset_v),
    .q     (vcount),
    .wrap  (v_wrap)
  );

  always_comb begin
    h_nxt     = next_count(hcount, pix_en, preset, preset_h, H_TOTAL);
    v_nxt     = next_count(vcount, v_en, preset, preset_v, V_TOTAL);
    hsync_n_d = ~in_window(h_nxt, H_SYNC_START, H_SYNC_END);
    vsync_n_d = ~in_window(v_nxt, V_SYNC_START, V_SYNC_END);
    hblank_d  = (32'(h_nxt) >= H_ACTIVE);
    vblank_d  = (32'(v_nxt) >= V_ACTIVE);
    blank_d   = hblank_d | vblank_d;
    eol_d     = h_wrap;
    eof_d     = h_wrap & v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      hblank_q  <= 1'b0;
      vblank_q  <= 1'b0;
      blank_q   <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      blank_q   <= blank_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
    end
  end

  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;
  assign hblank  = hblank_q;
  assign vblank  = vblank_q;
  assign blank   = blank_q;
  assign eol     = eol_q;
  assign eof     = eof_q;

endmodule

// File: tb/tb_video_timing_decoder.sv
// Directed bench for video_timing_decoder: reset, line scan, sync windows, slow strobe, preset, mid-line reset.
module tb_video_timing_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       preset;
  logic [8:0] preset_h;
  logic [8:0] preset_v;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       hsync_n, vsync_n, hblank, vblank, blank, eol, eof;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_timing_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .pix_en   (pix_en),
    .preset   (preset),
    .preset_h (preset_h),
    .preset_v (preset_v),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n),
    .hblank   (hblank),
    .vblank   (vblank),
    .blank    (blank),
    .eol      (eol),
    .eof      (eof)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b0; preset = 1'b0; preset_h = '0; preset_v = '0;
    step(); step();
    checks++;
    if ({hcount, vcount} !== 18'd0) begin
      failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hcount, vcount);
    end
    checks++;
    if ({hsync_n, vsync_n} !== 2'b11) begin
      failures++; $display("FAIL reset_syncs got=%b exp=11", {hsync_n, vsync_n});
    end
    checks++;
    if ({hblank, vblank, blank, eol, eof} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {hblank, vblank, blank, eol, eof});
    end
    reset = 1'b0;
    step();
    checks++;
    if (hcount !== 9'd0 || eol !== 1'b0) begin
      failures++; $display("FAIL idle_hold got h=%0d eol=%b exp h=0 eol=0", hcount, eol);
    end
  endtask

  task automatic test_line();
    int eol_n = 0;
    int eof_n = 0;
    int exp_h, exp_v;
    pix_en = 1'b1;
    for (int i = 1; i <= 384; i++) begin
      step();
      exp_h = i % 384;
      exp_v = (i == 384) ? 1 : 0;
      if (eol) eol_n++;
      if (eof) eof_n++;
      checks++;
      if (hcount !== 9'(exp_h) || vcount !== 9'(exp_v)) begin
        failures++; $display("FAIL line_count i=%0d got=%0d/%0d exp=%0d/%0d", i, hcount, vcount, exp_h, exp_v);
      end
      checks++;
      if (hblank !== (exp_h >= 256) || hsync_n !== !(exp_h >= 288 && exp_h < 320)) begin
        failures++; $display("FAIL line_decode h=%0d got hblank=%b hsync_n=%b", exp_h, hblank, hsync_n);
      end
      checks++;
      if (eol !== (i == 384)) begin
        failures++; $display("FAIL line_eol i=%0d got=%b exp=%b", i, eol, (i == 384));
      end
    end
    checks++;
    if (eol_n != 1 || eof_n != 0) begin
      failures++; $display("FAIL line_strobe_count got eol=%0d eof=%0d exp eol=1 eof=0", eol_n, eof_n);
    end
    pix_en = 1'b0;
    step();
    checks++;
    if (eol !== 1'b0 || hcount !== 9'd0 || vcount !== 9'd1) begin
      failures++; $display("FAIL line_hold got eol=%b h=%0d v=%0d exp 0/0/1", eol, hcount, vcount);
    end
  endtask

  task automatic test_scan_line10();
    int lows = 0;
    int first_low = -1;
    int last_low = -1;
    int hb_n = 0;
    int bad_blank = 0;
    int bad_vblank = 0;
    preset = 1'b1; preset_h = 9'd0; preset_v = 9'd10; pix_en = 1'b0;
    step();
    preset = 1'b0;
    checks++;
    if (hcount !== 9'd0 || vcount !== 9'd10 || eol !== 1'b0 || hsync_n !== 1'b1) begin
      failures++; $display("FAIL l10_preset got h=%0d v=%0d eol=%b hs=%b", hcount, vcount, eol, hsync_n);
    end
    pix_en = 1'b1;
    for (int i = 1; i < 384; i++) begin
      step();
      if (!hsync_n) begin
        lows++;
        if (first_low < 0) first_low = int'(hcount);
        last_low = int'(hcount);
      end
      if (hblank) hb_n++;
      if (blank !== hblank) bad_blank++;
      if (vblank !== 1'b0) bad_vblank++;
    end
    pix_en = 1'b0;
    checks++;
    if (lows != 32 || first_low != 288 || last_low != 319) begin
      failures++; $display("FAIL l10_hsync got n=%0d first=%0d last=%0d exp 32/288/319", lows, first_low, last_low);
    end
    checks++;
    if (hb_n != 128) begin
      failures++; $display("FAIL l10_hblank got=%0d exp=128", hb_n);
    end
    checks++;
    if (bad_blank != 0 || bad_vblank != 0) begin
      failures++; $display("FAIL l10_blank got bad_blank=%0d bad_vblank=%0d exp 0/0", bad_blank, bad_vblank);
    end
  endtask

  task automatic test_vsync();
    int lows = 0;
    int first_v = -1;
    int last_v = -1;
    preset = 1'b1; preset_h = 9'd0; preset_v = 9'd243;
    step();
    preset = 1'b0;
    checks++;
    if (vblank !== 1'b1 || blank !== 1'b1 || vsync_n !== 1'b1) begin
      failures++; $display("FAIL vs_preset got vblank=%b blank=%b vsync_n=%b exp 1/1/1", vblank, blank, vsync_n);
    end
    pix_en = 1'b1;
    for (int i = 0; i < 5 * 384; i++) begin
      step();
      if (hcount == 9'd0 && !vsync_n) begin
        lows++;
        if (first_v < 0) first_v = int'(vcount);
        last_v = int'(vcount);
      end
    end
    pix_en = 1'b0;
    checks++;
    if (lows != 3 || first_v != 244 || last_v != 246) begin
      failures++; $display("FAIL vsync_lines got n=%0d first=%0d last=%0d exp 3/244/246", lows, first_v, last_v);
    end
  endtask

  task automatic test_slow_enable();
    logic [8:0] exp_h [4];
    int eol_cycles = 0;
    exp_h[0] = 9'd382; exp_h[1] = 9'd383; exp_h[2] = 9'd0; exp_h[3] = 9'd1;
    preset = 1'b1; preset_h = 9'd381; preset_v = 9'd5;
    step();
    preset = 1'b0;
    for (int g = 0; g < 4; g++) begin
      pix_en = 1'b1;
      step();
      pix_en = 1'b0;
      if (eol) eol_cycles++;
      checks++;
      if (hcount !== exp_h[g]) begin
        failures++; $display("FAIL slow_adv g=%0d got=%0d exp=%0d", g, hcount, exp_h[g]);
      end
      for (int k = 0; k < 3; k++) begin
        step();
        if (eol) eol_cycles++;
        checks++;
        if (hcount !== exp_h[g] || eol !== 1'b0) begin
          failures++; $display("FAIL slow_hold g=%0d got h=%0d eol=%b exp h=%0d eol=0", g, hcount, eol, exp_h[g]);
        end
      end
    end
    checks++;
    if (eol_cycles != 1 || vcount !== 9'd6) begin
      failures++; $display("FAIL slow_eol got eol_cycles=%0d v=%0d exp 1/6", eol_cycles, vcount);
    end
  endtask

  task automatic test_preset_wrap();
    preset = 1'b1; pix_en = 1'b1; preset_h = 9'd383; preset_v = 9'd261;
    step();
    preset = 1'b0;
    checks++;
    if (hcount !== 9'd383 || vcount !== 9'd261 || eol !== 1'b0 || eof !== 1'b0) begin
      failures++; $display("FAIL pw_preset got h=%0d v=%0d eol=%b eof=%b exp 383/261/0/0", hcount, vcount, eol, eof);
    end
    checks++;
    if ({hblank, vblank, blank, vsync_n} !== 4'b1111) begin
      failures++; $display("FAIL pw_decode got=%b exp=1111", {hblank, vblank, blank, vsync_n});
    end
    step();
    pix_en = 1'b0;
    checks++;
    if (hcount !== 9'd0 || vcount !== 9'd0 || eol !== 1'b1 || eof !== 1'b1) begin
      failures++; $display("FAIL pw_wrap got h=%0d v=%0d eol=%b eof=%b exp 0/0/1/1", hcount, vcount, eol, eof);
    end
    checks++;
    if ({hblank, vblank, blank} !== 3'b000) begin
      failures++; $display("FAIL pw_wrap_blank got=%b exp=000", {hblank, vblank, blank});
    end
    step();
    checks++;
    if (eol !== 1'b0 || eof !== 1'b0 || hcount !== 9'd0) begin
      failures++; $display("FAIL pw_after got eol=%b eof=%b h=%0d exp 0/0/0", eol, eof, hcount);
    end
    preset = 1'b1; preset_h = 9'd511; preset_v = 9'd300;
    step();
    preset = 1'b0;
    checks++;
    if (hcount !== 9'd383 || vcount !== 9'd261) begin
      failures++; $display("FAIL pw_clamp got=%0d/%0d exp=383/261", hcount, vcount);
    end
  endtask

  task automatic test_reset_mid();
    preset = 1'b1; preset_h = 9'd300; preset_v = 9'd245; pix_en = 1'b0;
    step();
    preset = 1'b0;
    checks++;
    if ({hsync_n, vsync_n, hblank, vblank} !== 4'b0011) begin
      failures++; $display("FAIL mid_pre got=%b exp=0011", {hsync_n, vsync_n, hblank, vblank});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (hcount !== 9'd0 || vcount !== 9'd0 || {hsync_n, vsync_n} !== 2'b11 || {hblank, vblank, blank} !== 3'b000) begin
      failures++; $display("FAIL mid_reset got h=%0d v=%0d sync=%b blk=%b", hcount, vcount, {hsync_n, vsync_n}, {hblank, vblank, blank});
    end
    step();
    reset = 1'b0;
    pix_en = 1'b1;
    step();
    pix_en = 1'b0;
    checks++;
    if (hcount !== 9'd1 || vcount !== 9'd0) begin
      failures++; $display("FAIL mid_release got=%0d/%0d exp=1/0", hcount, vcount);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_scan_line10();
    test_vsync();
    test_slow_enable();
    test_preset_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
